bch_enroll_sequencer: RTL and testbench

Sequences a multi-block PUF enrollment through the BCH encoder wrapper. On a single go pulse it latches a wide PUF response and feeds it to the encoder one data block at a time. Each block gets its own start pulse and its own ECC base address in helper-data memory, and the sequencer waits for the encoder's write-back to finish before issuing the next block. It sits between the enrollment top-level control and the encoder wrapper, and it is the only driver of the wrapper's enable, start, data and base-address inputs.

---
 rtl/bch_enroll_sequencer_pkg.sv | 19 +
 rtl/bch_seq_timer.sv | 34 +++
 rtl/bch_enroll_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_bch_enroll_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_enroll_sequencer_pkg.sv
// Shared state encoding and timing constants for the BCH enrollment sequencer.
package bch_enroll_sequencer_pkg;

  localparam int C_BLK_IDX_W    = 8;
  localparam int C_ARM_CYCLES   = 2;
  localparam int C_START_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_RDY  = 3'd4,
    ST_NEXT      = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } state_t;

endpackage

// File: rtl/bch_seq_timer.sv
// Loadable down-counter guarding one encoder handshake phase; expires after
// C_TIMEOUT running cycles following a load.
module bch_seq_timer
  import bch_enroll_sequencer_pkg::*;
#(
  parameter int C_TIMEOUT = 1023
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_load,
  input  logic I_run,
  output logic O_expire
);

  localparam int C_W = $clog2(C_TIMEOUT + 1);

  logic [C_W-1:0] r_cnt;

  // Count down while running; the load value makes expiry land on the C_TIMEOUT-th cycle.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_cnt <= {C_W{1'b0}};
    end else if (I_load) begin
      r_cnt <= C_W'(C_TIMEOUT - 1);
    end else if (I_run && (r_cnt != {C_W{1'b0}})) begin
      r_cnt <= r_cnt - C_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign O_expire = I_run & (r_cnt == {C_W{1'b0}});

endmodule

// File: rtl/bch_enroll_sequencer.sv
// Feeds a latched PUF response to the BCH encoder wrapper one block at a time.
// Define BCH_SEQ_TIMEOUT_EN to add the per-handshake timeout and error path.
module bch_enroll_sequencer
  import bch_enroll_sequencer_pkg::*;
#(
  parameter int C_DATA_BITS     = 16,
  parameter int C_NUM_BLOCKS    = 4,
  parameter int C_ECC_BYTES     = 2,
  parameter int C_MEM_ADDR_SIZE = 10,
  parameter int C_BASE_ADDR     = 0,
  parameter int C_TIMEOUT       = 1023
) (
  input  logic                             I_clk,
  input  logic                             I_rst_n,
  input  logic                             I_go,
  input  logic [C_NUM_BLOCKS*C_DATA_BITS-1:0] I_resp,
  output logic                             O_busy,
  output logic                             O_done,
  output logic                             O_err,
  output logic [7:0]                       O_blk_idx,
  output logic                             O_enc_en,
  output logic                             O_enc_start,
  output logic [C_DATA_BITS-1:0]           O_enc_data,
  output logic [C_MEM_ADDR_SIZE-1:0]       O_enc_base,
  input  logic                             I_enc_ready
);

  if ((C_NUM_BLOCKS < 1) || (C_NUM_BLOCKS > 255) || (C_TIMEOUT < 1)) begin : g_param_guard
    $error("bch_enroll_sequencer: parameter out of range");
  end

  state_t                          r_state;
  state_t                          w_next;
  logic                            r_go_d;
  logic                            w_go_edge;
  logic [1:0]                      r_hold;
  logic [C_NUM_BLOCKS*C_DATA_BITS-1:0] r_buf;
  logic [C_BLK_IDX_W-1:0]          r_blk_idx;
  logic [C_BLK_IDX_W-1:0]          w_next_idx;
  logic [C_DATA_BITS-1:0]          w_next_data;
  logic                            w_last;
  logic                            w_expire;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_err;
  logic                            r_enc_en;
  logic                            r_enc_start;
  logic [C_DATA_BITS-1:0]          r_enc_data;
  logic [C_MEM_ADDR_SIZE-1:0]      r_enc_base;

  assign w_go_edge  = I_go & ~r_go_d;
  assign w_next_idx = r_blk_idx + C_BLK_IDX_W'(1);
  assign w_last     = (r_blk_idx == C_BLK_IDX_W'(C_NUM_BLOCKS - 1));

`ifdef BCH_SEQ_TIMEOUT_EN
  logic w_tmr_load;
  logic w_tmr_run;

  assign w_tmr_load = (w_next != r_state) &&
                      ((w_next == ST_WAIT_BUSY) || (w_next == ST_WAIT_RDY));
  assign w_tmr_run  = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_RDY);

  bch_seq_timer #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_timer (
    .I_clk    (I_clk),
    .I_rst_n  (I_rst_n),
    .I_load   (w_tmr_load),
    .I_run    (w_tmr_run),
    .O_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // Slice mux selecting the block that follows the one in flight.
  always_comb begin
    w_next_data = {C_DATA_BITS{1'b0}};
    for (int i = 0; i < C_NUM_BLOCKS; i++) begin
      if (w_next_idx == C_BLK_IDX_W'(i)) begin
        w_next_data = r_buf[i*C_DATA_BITS +: C_DATA_BITS];
      end else begin
        w_next_data = w_next_data;
      end
    end
  end

  // Next-state logic; a ready event wins over a simultaneous expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go_edge) w_next = ST_ARM;
        else           w_next = ST_IDLE;
      end
      ST_ARM: begin
        if (r_hold == 2'(C_ARM_CYCLES - 1)) w_next = ST_START;
        else                                w_next = ST_ARM;
      end
      ST_START: begin
        if (r_hold == 2'(C_START_CYCLES - 1)) w_next = ST_WAIT_BUSY;
        else                                  w_next = ST_START;
      end
      ST_WAIT_BUSY: begin
        if (!I_enc_ready)  w_next = ST_WAIT_RDY;
        else if (w_expire) w_next = ST_ERR;
        else               w_next = ST_WAIT_BUSY;
      end
      ST_WAIT_RDY: begin
        if (I_enc_ready)   w_next = ST_NEXT;
        else if (w_expire) w_next = ST_ERR;
        else               w_next = ST_WAIT_RDY;
      end
      ST_NEXT: begin
        if (w_last) w_next = ST_DONE;
        else        w_next = ST_START;
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, hold counter and all registered outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state     <= ST_IDLE;
      r_go_d      <= 1'b0;
      r_hold      <= 2'd0;
      r_buf       <= {(C_NUM_BLOCKS*C_DATA_BITS){1'b0}};
      r_blk_idx   <= {C_BLK_IDX_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_enc_en    <= 1'b0;
      r_enc_start <= 1'b0;
      r_enc_data  <= {C_DATA_BITS{1'b0}};
      r_enc_base  <= {C_MEM_ADDR_SIZE{1'b0}};
    end else begin
      r_state     <= w_next;
      r_go_d      <= I_go;
      r_enc_start <= (r_state == ST_START);
      r_done      <= (w_next == ST_DONE);
      if (w_next != r_state) begin
        r_hold <= 2'd0;
      end else if ((r_state == ST_ARM) || (r_state == ST_START)) begin
        r_hold <= r_hold + 2'd1;
      end else begin
        r_hold <= r_hold;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_go_edge) begin
            r_buf      <= I_resp;
            r_err      <= 1'b0;
            r_blk_idx  <= {C_BLK_IDX_W{1'b0}};
            r_enc_base <= C_MEM_ADDR_SIZE'(C_BASE_ADDR);
            r_enc_data <= I_resp[C_DATA_BITS-1:0];
            r_busy     <= 1'b1;
            r_enc_en   <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (w_next == ST_START) begin
            r_blk_idx  <= w_next_idx;
            r_enc_base <= r_enc_base + C_MEM_ADDR_SIZE'(C_ECC_BYTES);
            r_enc_data <= w_next_data;
          end else begin
            r_busy   <= 1'b0;
            r_enc_en <= 1'b0;
          end
        end
        ST_WAIT_BUSY, ST_WAIT_RDY: begin
          if (w_next == ST_ERR) begin
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
            r_enc_en <= 1'b0;
          end
        end
        default: begin
          r_busy <= r_busy;
        end
      endcase
    end
  end

  assign O_busy      = r_busy;
  assign O_done      = r_done;
  assign O_err       = r_err;
  assign O_blk_idx   = r_blk_idx;
  assign O_enc_en    = r_enc_en;
  assign O_enc_start = r_enc_start;
  assign O_enc_data  = r_enc_data;
  assign O_enc_base  = r_enc_base;

endmodule

// File: tb/tb_bch_enroll_sequencer.sv
// Directed self-checking bench: a single-block and a four-block sequencer, each
// driven by a small encoder ready model.
module tb_bch_enroll_sequencer;

  logic        clk;
  logic        rst_n;
  logic        go1, go4;
  logic [15:0] resp1;
  logic [63:0] resp4;
  logic        busy1, done1, err1, en1, start1, rdy1;
  logic [7:0]  blk1;
  logic [15:0] data1;
  logic [9:0]  base1;
  logic        busy4, done4, err4, en4, start4, rdy4;
  logic [7:0]  blk4;
  logic [15:0] data4;
  logic [9:0]  base4;
  logic        m_rdy1, m_rdy4, stall4, man_rdy4;
  int          n_cmp, n_bad;

  assign rdy1 = m_rdy1;
  assign rdy4 = stall4 ? man_rdy4 : m_rdy4;

  bch_enroll_sequencer #(
    .C_DATA_BITS(16), .C_NUM_BLOCKS(1), .C_ECC_BYTES(2),
    .C_MEM_ADDR_SIZE(10), .C_BASE_ADDR(0), .C_TIMEOUT(15)
  ) u_dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_go(go1), .I_resp(resp1),
    .O_busy(busy1), .O_done(done1), .O_err(err1), .O_blk_idx(blk1),
    .O_enc_en(en1), .O_enc_start(start1), .O_enc_data(data1),
    .O_enc_base(base1), .I_enc_ready(rdy1)
  );

  bch_enroll_sequencer #(
    .C_DATA_BITS(16), .C_NUM_BLOCKS(4), .C_ECC_BYTES(2),
    .C_MEM_ADDR_SIZE(10), .C_BASE_ADDR(10'h3FE), .C_TIMEOUT(15)
  ) u_dut4 (
    .I_clk(clk), .I_rst_n(rst_n), .I_go(go4), .I_resp(resp4),
    .O_busy(busy4), .O_done(done4), .O_err(err4), .O_blk_idx(blk4),
    .O_enc_en(en4), .O_enc_start(start4), .O_enc_data(data4),
    .O_enc_base(base4), .I_enc_ready(rdy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encoder model for the single-block instance: ready drops 4 cycles after start, rises 20 later.
  initial begin : model1
    int  ph, cnt;
    logic sprev;
    m_rdy1 = 1'b1; ph = 0; cnt = 0; sprev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ph = 0; m_rdy1 = 1'b1;
      end else if (ph == 0) begin
        if (start1 && !sprev) begin ph = 1; cnt = 0; end
      end else begin
        cnt++;
        if (ph == 1 && cnt == 4) begin m_rdy1 = 1'b0; ph = 2; cnt = 0; end
        else if (ph == 2 && cnt == 20) begin m_rdy1 = 1'b1; ph = 0; end
      end
      sprev = start1;
    end
  end

  // Encoder model for the four-block instance; ignores starts while stalled.
  initial begin : model4
    int  ph, cnt;
    logic sprev;
    m_rdy4 = 1'b1; ph = 0; cnt = 0; sprev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ph = 0; m_rdy4 = 1'b1;
      end else if (ph == 0) begin
        if (start4 && !sprev && !stall4) begin ph = 1; cnt = 0; end
      end else begin
        cnt++;
        if (ph == 1 && cnt == 4) begin m_rdy4 = 1'b0; ph = 2; cnt = 0; end
        else if (ph == 2 && cnt == 20) begin m_rdy4 = 1'b1; ph = 0; end
      end
      sprev = start4;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    logic [15:0] dat [4];
    logic [9:0]  bas [4];
    logic        seen, sp, rprev;
    int          starts, scyc, dones, maxidx;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; go1 = 1'b0; go4 = 1'b0; resp1 = 16'h0; resp4 = 64'h0;
    stall4 = 1'b0; man_rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin dat[i] = 16'h0; bas[i] = 10'h0; end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dut4_outs", 64'({busy4, done4, err4, blk4, en4, start4, data4, base4}), 64'd0);
    chk("rst_dut1_outs", 64'({busy1, done1, err1, blk1, en1, start1, data1, base1}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single block
    resp1 = 16'hA5C3; go1 = 1'b1;
    @(negedge clk);
    chk("b1_busy", 64'(busy1), 64'd1);
    chk("b1_en", 64'(en1), 64'd1);
    chk("b1_data", 64'(data1), 64'hA5C3);
    chk("b1_base", 64'(base1), 64'h0);
    go1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("b1_start_lo", 64'(start1), 64'd0);
    @(negedge clk);
    chk("b1_start_hi", 64'(start1), 64'd1);
    seen = 1'b0; rprev = rdy1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (rdy1 && !rprev) seen = 1'b1;
      rprev = rdy1;
    end
    chk("b1_rdy_rise", 64'(seen), 64'd1);
    @(negedge clk);
    chk("b1_done_early", 64'(done1), 64'd0);
    @(negedge clk);
    chk("b1_done", 64'(done1), 64'd1);
    chk("b1_busy_low", 64'(busy1), 64'd0);
    chk("b1_en_low", 64'(en1), 64'd0);
    @(negedge clk);
    chk("b1_done_pulse", 64'(done1), 64'd0);

    // Four blocks, go held high with an extra edge mid-run
    resp4 = 64'h4444_3333_2222_1111; go4 = 1'b1;
    starts = 0; scyc = 0; dones = 0; maxidx = 0; sp = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 60) go4 = 1'b0;
      if (c == 62) go4 = 1'b1;
      if (start4) scyc++;
      if (start4 && !sp) begin
        if (starts < 4) begin dat[starts] = data4; bas[starts] = base4; end
        starts++;
      end
      sp = start4;
      if (int'(blk4) > maxidx) maxidx = int'(blk4);
      if (done4) dones++;
    end
    chk("b4_starts", 64'(starts), 64'd4);
    chk("b4_start_cycles", 64'(scyc), 64'd12);
    chk("b4_dones", 64'(dones), 64'd1);
    chk("b4_max_idx", 64'(maxidx), 64'd3);
    chk("b4_busy_end", 64'(busy4), 64'd0);
    chk("b4_data0", 64'(dat[0]), 64'h1111);
    chk("b4_data1", 64'(dat[1]), 64'h2222);
    chk("b4_data2", 64'(dat[2]), 64'h3333);
    chk("b4_data3", 64'(dat[3]), 64'h4444);
    chk("b4_base0", 64'(bas[0]), 64'h3FE);
    chk("b4_base1", 64'(bas[1]), 64'h000);
    chk("b4_base2", 64'(bas[2]), 64'h002);
    chk("b4_base3", 64'(bas[3]), 64'h004);
    go4 = 1'b0;
    @(negedge clk);

    // Asynchronous reset during block 2, then restart from block 0
    resp4 = 64'hDDDD_CCCC_BBBB_AAAA; go4 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (blk4 == 8'd2) seen = 1'b1;
    end
    chk("rst_reach_blk2", 64'(seen), 64'd1);
    rst_n = 1'b0; go4 = 1'b0;
    #1;
    chk("rst_async_outs", 64'({busy4, done4, err4, blk4, en4, start4, data4, base4}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go4 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (start4) seen = 1'b1;
    end
    chk("rst_restart_start", 64'(seen), 64'd1);
    chk("rst_restart_data", 64'(data4), 64'hAAAA);
    chk("rst_restart_base", 64'(base4), 64'h3FE);
    chk("rst_restart_idx", 64'(blk4), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    chk("rst_restart_done", 64'(seen), 64'd1);
    go4 = 1'b0;
    @(negedge clk);

    stall4 = 1'b1; man_rdy4 = 1'b1;
`ifdef BCH_SEQ_TIMEOUT_EN
    // Ready never drops: timeout in WAIT_BUSY
    go4 = 1'b1;
    seen = 1'b0; dones = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done4) dones++;
      if (err4) seen = 1'b1;
    end
    chk("to_err", 64'(seen), 64'd1);
    chk("to_en_low", 64'(en4), 64'd0);
    chk("to_busy_low", 64'(busy4), 64'd0);
    chk("to_no_done", 64'(dones), 64'd0);
    stall4 = 1'b0; go4 = 1'b0;
    @(negedge clk);
    go4 = 1'b1;
    @(negedge clk);
    chk("to_err_clear", 64'(err4), 64'd0);
    chk("to_rearm_busy", 64'(busy4), 64'd1);
`else
    // Ready stalled for 5000 cycles with no timeout
    go4 = 1'b1;
    repeat (5000) @(negedge clk);
    chk("st_busy", 64'(busy4), 64'd1);
    chk("st_err", 64'(err4), 64'd0);
    chk("st_en", 64'(en4), 64'd1);
    chk("st_idx", 64'(blk4), 64'd0);
    man_rdy4 = 1'b0;
    repeat (3) @(negedge clk);
    man_rdy4 = 1'b1; stall4 = 1'b0;
`endif
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    chk("tail_done", 64'(seen), 64'd1);
    chk("tail_err", 64'(err4), 64'd0);
    go4 = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
